lru_ctrl: RTL and testbench

- Replacement controller for the 8-way set-associative cache.
- Holds one 3-bit LRU age per way per set.
- On each lookup it selects the target way: the hit way, or the LRU victim on a miss. It then updates the ages through the 8-to-1 3-bit age selection path and returns the way to the cache control FSM over a valid/ready handshake.
- Sits between the tag-compare stage and the data/tag array write-enable logic.

---
 rtl/lru_ctrl_if.sv | 25 ++
 rtl/lru_ctrl.sv | 133 +++++++++++++
 tb/tb_lru_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/lru_ctrl_if.sv
// Lookup-request / way-response handshake between the cache control FSM (master)
// and the LRU replacement controller (slave).
interface lru_ctrl_if #(
    parameter int SET_BITS = 2
);
    logic                req_valid;
    logic                req_ready;
    logic [SET_BITS-1:0] req_set;
    logic                req_hit;
    logic [2:0]          req_way;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [2:0]          rsp_way;
    logic                rsp_miss;

    modport master (
        output req_valid, req_set, req_hit, req_way, rsp_ready,
        input  req_ready, rsp_valid, rsp_way, rsp_miss
    );

    modport slave (
        input  req_valid, req_set, req_hit, req_way, rsp_ready,
        output req_ready, rsp_valid, rsp_way, rsp_miss
    );
endinterface

// File: rtl/lru_ctrl.sv
// 8-way age-based LRU replacement controller: picks hit way or LRU victim, re-ages the set.
// Optional hit/miss statistics counters are built when LRU_STATS_EN is defined.
module lru_ctrl #(
    parameter int NUM_SETS = 4,
    parameter int SET_BITS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    lru_ctrl_if.slave   bus,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        UPDATE,
        RESP
    } state_t;

    state_t              state_q;
    logic [2:0]          age_q [NUM_SETS][8];
    logic [SET_BITS-1:0] set_q;
    logic                hit_q;
    logic [2:0]          way_q;
    logic [2:0]          tgt_q;
    logic [2:0]          tgt_age_q;
    logic [2:0]          rsp_way_q;
    logic                rsp_miss_q;
    logic                req_ready_q;
    logic                rsp_valid_q;

    logic [2:0]          victim_d;
    logic [2:0]          tgt_d;
    logic [2:0]          tgt_age_d;

    // Scanning downward lets the lowest-indexed age-7 way win.
    always_comb begin
        victim_d = 3'd0;
        for (int w = 7; w >= 0; w--) begin
            if (age_q[set_q][w] == 3'd7) victim_d = 3'(w);
        end
        tgt_d     = hit_q ? way_q : victim_d;
        tgt_age_d = age_q[set_q][tgt_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            set_q       <= '0;
            hit_q       <= 1'b0;
            way_q       <= 3'd0;
            tgt_q       <= 3'd0;
            tgt_age_q   <= 3'd0;
            rsp_way_q   <= 3'd0;
            rsp_miss_q  <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            // NOTE: the age array is reset on purpose; every set must restart as a valid permutation.
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < 8; w++) age_q[s][w] <= 3'(w);
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        set_q       <= bus.req_set;
                        hit_q       <= bus.req_hit;
                        way_q       <= bus.req_hit ? bus.req_way : 3'd0;
                        req_ready_q <= 1'b0;
                        state_q     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    tgt_q     <= tgt_d;
                    tgt_age_q <= tgt_age_d;
                    state_q   <= UPDATE;
                end
                UPDATE: begin
                    for (int w = 0; w < 8; w++) begin
                        if (3'(w) == tgt_q) begin
                            age_q[set_q][w] <= 3'd0;
                        end else if (age_q[set_q][w] < tgt_age_q) begin
                            age_q[set_q][w] <= age_q[set_q][w] + 3'd1;
                        end
                    end
                    rsp_way_q   <= tgt_q;
                    rsp_miss_q  <= !hit_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_way   = rsp_way_q;
    assign bus.rsp_miss  = rsp_miss_q;

`ifdef LRU_STATS_EN
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;
    logic        rsp_fire;

    assign rsp_fire = rsp_valid_q && bus.rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= 16'd0;
            miss_cnt_q <= 16'd0;
        end else if (rsp_fire) begin
            if (!rsp_miss_q && hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
            if (rsp_miss_q && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    assign hit_cnt  = 16'd0;
    assign miss_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_lru_ctrl.sv
// Self-checking bench for lru_ctrl: directed vector table, multi-cycle corner cases,
// and randomized traffic against a recency-list reference model.
module tb_lru_ctrl;
    localparam int NUM_SETS = 4;
    localparam int SET_BITS = 2;
`ifdef LRU_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    lru_ctrl_if #(.SET_BITS(SET_BITS)) bus ();

    lru_ctrl #(.NUM_SETS(NUM_SETS), .SET_BITS(SET_BITS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int set;
        bit hit;
        int way;
        int exp_way;
        bit exp_miss;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    // Reference model: per set, ways listed from most to least recently used.
    int   ord [NUM_SETS][8];
    int   m_hits;
    int   m_misses;
    vec_t vecs [10];
    int   exp_set0 [8];
    int   exp_set1 [8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int s = 0; s < NUM_SETS; s++)
            for (int i = 0; i < 8; i++) ord[s][i] = i;
        m_hits   = 0;
        m_misses = 0;
    endfunction

    function automatic int model_age(input int s, input int w);
        for (int i = 0; i < 8; i++) if (ord[s][i] == w) return i;
        return -1;
    endfunction

    function automatic void model_touch(input int s, input int w);
        int p;
        p = model_age(s, w);
        for (int i = p; i > 0; i--) ord[s][i] = ord[s][i-1];
        ord[s][0] = w;
    endfunction

    task automatic check_ages(input string tag);
        for (int s = 0; s < NUM_SETS; s++)
            for (int w = 0; w < 8; w++)
                check($sformatf("%s age s%0d w%0d", tag, s, w), int'(dut.age_q[s][w]), model_age(s, w));
    endtask

    task automatic check_set_const(input string tag, input int s, input int exp [8]);
        for (int w = 0; w < 8; w++)
            check($sformatf("%s const age s%0d w%0d", tag, s, w), int'(dut.age_q[s][w]), exp[w]);
    endtask

    task automatic do_txn(input int s, input bit hit, input int way, input int hold, input string tag,
                          output int rway, output int rmiss);
        int n;
        int exp_way;
        bit exp_miss;
        logic [2:0] held_way;
        exp_miss = !hit;
        exp_way  = hit ? way : ord[s][7];
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " req_ready before request"}, int'(bus.req_ready), 1);
        bus.req_valid = 1'b1;
        bus.req_set   = SET_BITS'(s);
        bus.req_hit   = hit;
        bus.req_way   = hit ? 3'(way) : 3'($urandom);
        @(negedge clk);
        check({tag, " req_ready busy"}, int'(bus.req_ready), 0);
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            bus.req_set = SET_BITS'($urandom);
            bus.req_hit = 1'($urandom);
            bus.req_way = 3'($urandom);
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, n + 1, 3);
        check({tag, " rsp_way"}, int'(bus.rsp_way), exp_way);
        check({tag, " rsp_miss"}, int'(bus.rsp_miss), int'(exp_miss));
        rway     = int'(bus.rsp_way);
        rmiss    = int'(bus.rsp_miss);
        held_way = bus.rsp_way;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold rsp_valid"}, int'(bus.rsp_valid), 1);
            check({tag, " hold rsp_way"}, int'(bus.rsp_way), int'(held_way));
            check({tag, " hold req_ready"}, int'(bus.req_ready), 0);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check({tag, " req_ready after rsp"}, int'(bus.req_ready), 1);
        check({tag, " rsp_valid after rsp"}, int'(bus.rsp_valid), 0);
        model_touch(s, exp_way);
        if (hit) m_hits++;
        else     m_misses++;
    endtask

    task automatic check_counters(input string tag);
        check({tag, " hit_cnt"},  int'(hit_cnt),  STATS ? m_hits : 0);
        check({tag, " miss_cnt"}, int'(miss_cnt), STATS ? m_misses : 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int rway;
        int rmiss;

        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_set   = '0;
        bus.req_hit   = 1'b0;
        bus.req_way   = 3'd0;
        bus.rsp_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);

        check("reset req_ready", int'(bus.req_ready), 1);
        check("reset rsp_valid", int'(bus.rsp_valid), 0);
        check("reset rsp_way",   int'(bus.rsp_way),   0);
        check("reset rsp_miss",  int'(bus.rsp_miss),  0);
        check_counters("reset");
        check_ages("reset");
        rst_n = 1'b1;
        @(negedge clk);

        vecs[0] = '{0, 1'b0, 0, 7, 1'b1};
        vecs[1] = '{0, 1'b0, 0, 6, 1'b1};
        vecs[2] = '{1, 1'b1, 3, 3, 1'b0};
        vecs[3] = '{1, 1'b1, 3, 3, 1'b0};
        vecs[4] = '{1, 1'b0, 0, 7, 1'b1};
        vecs[5] = '{1, 1'b0, 0, 6, 1'b1};
        vecs[6] = '{0, 1'b1, 7, 7, 1'b0};
        vecs[7] = '{0, 1'b0, 0, 5, 1'b1};
        vecs[8] = '{2, 1'b1, 0, 0, 1'b0};
        vecs[9] = '{3, 1'b0, 0, 7, 1'b1};
        exp_set0 = '{2, 3, 4, 5, 6, 7, 0, 1};
        exp_set1 = '{1, 2, 3, 0, 4, 5, 6, 7};

        for (int i = 0; i < 10; i++) begin
            do_txn(vecs[i].set, vecs[i].hit, vecs[i].way, 0, $sformatf("vec%0d", i), rway, rmiss);
            check($sformatf("vec%0d table way", i),  rway,  vecs[i].exp_way);
            check($sformatf("vec%0d table miss", i), rmiss, int'(vecs[i].exp_miss));
            check_ages($sformatf("vec%0d", i));
            if (i == 1) check_set_const("two misses", 0, exp_set0);
            if (i == 2) check_set_const("hit way3", 1, exp_set1);
        end
        check_counters("after table");

        do_txn(2, 1'b0, 0, 5, "hold5", rway, rmiss);
        check_ages("hold5");

        // Abort a request while it is in UPDATE.
        bus.req_valid = 1'b1;
        bus.req_set   = SET_BITS'(3);
        bus.req_hit   = 1'b0;
        bus.req_way   = 3'd0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("abort rsp_valid", int'(bus.rsp_valid), 0);
        check("abort req_ready", int'(bus.req_ready), 1);
        check_counters("abort");
        check_ages("abort");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post-abort rsp_valid", int'(bus.rsp_valid), 0);
            check("post-abort req_ready", int'(bus.req_ready), 1);
        end
        check_ages("post-abort");

        do_txn(0, 1'b1, 2, 0, "stats h1", rway, rmiss);
        do_txn(0, 1'b0, 0, 1, "stats m1", rway, rmiss);
        do_txn(1, 1'b1, 5, 0, "stats h2", rway, rmiss);
        do_txn(2, 1'b0, 0, 2, "stats m2", rway, rmiss);
        do_txn(0, 1'b1, 2, 0, "stats h3", rway, rmiss);
        check("stats 3 hits",   int'(hit_cnt),  STATS ? 3 : 0);
        check("stats 2 misses", int'(miss_cnt), STATS ? 2 : 0);
        check_ages("stats");

        for (int i = 0; i < 150; i++) begin
            do_txn($urandom_range(0, NUM_SETS - 1), 1'($urandom), $urandom_range(0, 7),
                   $urandom_range(0, 2), $sformatf("rnd%0d", i), rway, rmiss);
            check_ages($sformatf("rnd%0d", i));
        end
        check_counters("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
